// File: rtl/stream_checker.sv
// Checks an incrementing 32-bit word stream in fixed-length bursts and reports
// pass/short/overrun status plus details of the first sequence mismatch.
module stream_checker #(
    parameter int unsigned BURST_LEN = 8192
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] data_in,
    input  logic        valid_in,
    input  logic        clear_in,
    output logic        busy_out,
    output logic        done_out,
    output logic        pass_out,
    output logic        short_out,
    output logic        overrun_out,
    output logic [15:0] word_count_out,
    output logic [15:0] error_count_out,
    output logic [15:0] first_err_idx_out,
    output logic [31:0] first_err_data_out,
    output logic [31:0] first_err_exp_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] LAST_WORD = 16'(BURST_LEN);

    state_t      state_r, state_s;
    logic [31:0] exp_r, exp_s;
    logic [15:0] wcnt_r, wcnt_s;
    logic [15:0] ecnt_r, ecnt_s;
    logic [15:0] idx_r, idx_s;
    logic [31:0] fdata_r, fdata_s;
    logic [31:0] fexp_r, fexp_s;
    logic        short_r, short_s;
    logic        pass_r, pass_s;
    logic        ovr_r, ovr_s;
    logic        busy_r, done_r;
    logic        mismatch_s;

    // Next-state and next-result computation; every register holds by default.
    always_comb begin
        state_s    = state_r;
        exp_s      = exp_r;
        wcnt_s     = wcnt_r;
        ecnt_s     = ecnt_r;
        idx_s      = idx_r;
        fdata_s    = fdata_r;
        fexp_s     = fexp_r;
        short_s    = short_r;
        pass_s     = pass_r;
        ovr_s      = ovr_r;
        mismatch_s = (data_in != exp_r);
        case (state_r)
            IDLE: begin
                if (valid_in) begin
                    // Seed word: never compared, starts a fresh result set.
                    state_s = RUN;
                    wcnt_s  = 16'd1;
                    exp_s   = data_in + 32'd1;
                    ecnt_s  = 16'd0;
                    idx_s   = 16'd0;
                    fdata_s = 32'd0;
                    fexp_s  = 32'd0;
                    short_s = 1'b0;
                    pass_s  = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (valid_in) begin
                    wcnt_s = wcnt_r + 16'd1;
                    exp_s  = data_in + 32'd1;
                    if (mismatch_s) begin
                        if (ecnt_r != 16'hFFFF) begin
                            ecnt_s = ecnt_r + 16'd1;
                        end else begin
                            ecnt_s = ecnt_r;
                        end
                        if (ecnt_r == 16'd0) begin
                            idx_s   = wcnt_r;
                            fdata_s = data_in;
                            fexp_s  = exp_r;
                        end else begin
                            idx_s = idx_r;
                        end
                    end else begin
                        ecnt_s = ecnt_r;
                    end
                    if (wcnt_s == LAST_WORD) begin
                        state_s = DONE;
                        pass_s  = (ecnt_s == 16'd0);
                    end else begin
                        state_s = RUN;
                    end
                end else begin
                    state_s = DONE;
                    short_s = 1'b1;
                    pass_s  = 1'b0;
                end
            end
            DONE: begin
                state_s = IDLE;
                if (valid_in) begin
                    ovr_s = 1'b1;
                end else begin
                    ovr_s = ovr_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and result registers; reset and clear share the same priority path.
    always_ff @(posedge clk_in) begin
        if (rst_in || clear_in) begin
            state_r <= IDLE;
            exp_r   <= 32'd0;
            wcnt_r  <= 16'd0;
            ecnt_r  <= 16'd0;
            idx_r   <= 16'd0;
            fdata_r <= 32'd0;
            fexp_r  <= 32'd0;
            short_r <= 1'b0;
            pass_r  <= 1'b0;
            ovr_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            exp_r   <= exp_s;
            wcnt_r  <= wcnt_s;
            ecnt_r  <= ecnt_s;
            idx_r   <= idx_s;
            fdata_r <= fdata_s;
            fexp_r  <= fexp_s;
            short_r <= short_s;
            pass_r  <= pass_s;
            ovr_r   <= ovr_s;
            busy_r  <= (state_s == RUN);
            done_r  <= (state_s == DONE);
        end
    end

    assign busy_out           = busy_r;
    assign done_out           = done_r;
    assign pass_out           = pass_r;
    assign short_out          = short_r;
    assign overrun_out        = ovr_r;
    assign word_count_out     = wcnt_r;
    assign error_count_out    = ecnt_r;
    assign first_err_idx_out  = idx_r;
    assign first_err_data_out = fdata_r;
    assign first_err_exp_out  = fexp_r;

endmodule

// File: tb/tb_stream_checker.sv
// Directed bench for stream_checker: three instances (BURST_LEN 8192, 5, 4)
// share one stimulus stream; each test checks the instance it targets.
module tb_stream_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] data = 32'd0;

    logic        busy [3];
    logic        done [3];
    logic        pass [3];
    logic        short_b [3];
    logic        ovr [3];
    logic [15:0] wcnt [3];
    logic [15:0] ecnt [3];
    logic [15:0] fidx [3];
    logic [31:0] fdata [3];
    logic [31:0] fexp [3];

    int n_cmp = 0;
    int n_bad = 0;
    int pulses;

    always #5 clk = ~clk;

    stream_checker #(.BURST_LEN(8192)) dut_8k (
        .clk_in(clk), .rst_in(rst), .data_in(data), .valid_in(valid), .clear_in(clear),
        .busy_out(busy[0]), .done_out(done[0]), .pass_out(pass[0]), .short_out(short_b[0]),
        .overrun_out(ovr[0]), .word_count_out(wcnt[0]), .error_count_out(ecnt[0]),
        .first_err_idx_out(fidx[0]), .first_err_data_out(fdata[0]), .first_err_exp_out(fexp[0])
    );

    stream_checker #(.BURST_LEN(5)) dut_5 (
        .clk_in(clk), .rst_in(rst), .data_in(data), .valid_in(valid), .clear_in(clear),
        .busy_out(busy[1]), .done_out(done[1]), .pass_out(pass[1]), .short_out(short_b[1]),
        .overrun_out(ovr[1]), .word_count_out(wcnt[1]), .error_count_out(ecnt[1]),
        .first_err_idx_out(fidx[1]), .first_err_data_out(fdata[1]), .first_err_exp_out(fexp[1])
    );

    stream_checker #(.BURST_LEN(4)) dut_4 (
        .clk_in(clk), .rst_in(rst), .data_in(data), .valid_in(valid), .clear_in(clear),
        .busy_out(busy[2]), .done_out(done[2]), .pass_out(pass[2]), .short_out(short_b[2]),
        .overrun_out(ovr[2]), .word_count_out(wcnt[2]), .error_count_out(ecnt[2]),
        .first_err_idx_out(fidx[2]), .first_err_data_out(fdata[2]), .first_err_exp_out(fexp[2])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then stable and inputs may be changed.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        valid = 1'b0;
        clear = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d);
        valid = 1'b1;
        data  = d;
        tick();
    endtask

    task automatic check_zero(input int k);
        check_eq("zero_busy", {31'd0, busy[k]}, 32'd0);
        check_eq("zero_done", {31'd0, done[k]}, 32'd0);
        check_eq("zero_pass", {31'd0, pass[k]}, 32'd0);
        check_eq("zero_short", {31'd0, short_b[k]}, 32'd0);
        check_eq("zero_ovr", {31'd0, ovr[k]}, 32'd0);
        check_eq("zero_wcnt", {16'd0, wcnt[k]}, 32'd0);
        check_eq("zero_ecnt", {16'd0, ecnt[k]}, 32'd0);
        check_eq("zero_fidx", {16'd0, fidx[k]}, 32'd0);
        check_eq("zero_fdata", fdata[k], 32'd0);
        check_eq("zero_fexp", fexp[k], 32'd0);
    endtask

    initial begin
        // Reset state on all instances
        do_reset();
        for (int k = 0; k < 3; k++) check_zero(k);

        // Full 8192-word burst, data 0..8191
        pulses = 0;
        for (int i = 0; i < 8192; i++) begin
            send_word(32'(i));
            if (done[0]) pulses++;
        end
        check_eq("full_done_last", {31'd0, done[0]}, 32'd1);
        check_eq("full_busy_done", {31'd0, busy[0]}, 32'd0);
        valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done[0]) pulses++;
        end
        check_eq("full_pulses", 32'(pulses), 32'd1);
        check_eq("full_wcnt", {16'd0, wcnt[0]}, 32'd8192);
        check_eq("full_ecnt", {16'd0, ecnt[0]}, 32'd0);
        check_eq("full_pass", {31'd0, pass[0]}, 32'd1);
        check_eq("full_short", {31'd0, short_b[0]}, 32'd0);

        // Wrap through 0xFFFFFFFF, BURST_LEN 4
        do_reset();
        send_word(32'hFFFF_FFFE);
        check_eq("wrap_busy", {31'd0, busy[2]}, 32'd1);
        send_word(32'hFFFF_FFFF);
        send_word(32'h0000_0000);
        send_word(32'h0000_0001);
        valid = 1'b0;
        check_eq("wrap_done", {31'd0, done[2]}, 32'd1);
        check_eq("wrap_ecnt", {16'd0, ecnt[2]}, 32'd0);
        check_eq("wrap_pass", {31'd0, pass[2]}, 32'd1);
        check_eq("wrap_wcnt", {16'd0, wcnt[2]}, 32'd4);

        // Single bad word 10,11,99,13,14 with BURST_LEN 5
        do_reset();
        send_word(32'd10);
        send_word(32'd11);
        send_word(32'd99);
        send_word(32'd13);
        send_word(32'd14);
        valid = 1'b0;
        check_eq("err_done", {31'd0, done[1]}, 32'd1);
        check_eq("err_ecnt", {16'd0, ecnt[1]}, 32'd2);
        check_eq("err_idx", {16'd0, fidx[1]}, 32'd2);
        check_eq("err_data", fdata[1], 32'd99);
        check_eq("err_exp", fexp[1], 32'd12);
        check_eq("err_pass", {31'd0, pass[1]}, 32'd0);
        tick();
        check_eq("err_done_1cyc", {31'd0, done[1]}, 32'd0);
        check_eq("err_hold_ecnt", {16'd0, ecnt[1]}, 32'd2);

        // Short burst: 100 words, then valid drops
        do_reset();
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            send_word(32'(i + 500));
            if (done[0]) pulses++;
        end
        valid = 1'b0;
        check_eq("short_busy_run", {31'd0, busy[0]}, 32'd1);
        tick();
        check_eq("short_done", {31'd0, done[0]}, 32'd1);
        if (done[0]) pulses++;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done[0]) pulses++;
        end
        check_eq("short_pulses", 32'(pulses), 32'd1);
        check_eq("short_flag", {31'd0, short_b[0]}, 32'd1);
        check_eq("short_wcnt", {16'd0, wcnt[0]}, 32'd100);
        check_eq("short_pass", {31'd0, pass[0]}, 32'd0);

        // Overrun: BURST_LEN+1 valid cycles on BURST_LEN 4, then a new burst
        do_reset();
        for (int i = 0; i < 5; i++) send_word(32'(i));
        check_eq("ovr_flag", {31'd0, ovr[2]}, 32'd1);
        check_eq("ovr_wcnt", {16'd0, wcnt[2]}, 32'd4);
        check_eq("ovr_pass_held", {31'd0, pass[2]}, 32'd1);
        send_word(32'd20);
        check_eq("ovr_reseed_busy", {31'd0, busy[2]}, 32'd1);
        check_eq("ovr_reseed_wcnt", {16'd0, wcnt[2]}, 32'd1);
        check_eq("ovr_reseed_pass", {31'd0, pass[2]}, 32'd0);
        send_word(32'd21);
        send_word(32'd22);
        send_word(32'd23);
        valid = 1'b0;
        check_eq("ovr_b2_done", {31'd0, done[2]}, 32'd1);
        check_eq("ovr_b2_pass", {31'd0, pass[2]}, 32'd1);
        check_eq("ovr_sticky", {31'd0, ovr[2]}, 32'd1);

        // clear_in wins over a valid word and wipes results
        clear = 1'b1;
        send_word(32'd77);
        clear = 1'b0;
        valid = 1'b0;
        check_zero(2);
        tick();
        check_eq("clr_no_seed", {31'd0, busy[2]}, 32'd0);

        // Reset mid-burst at word 50, then a normal burst
        do_reset();
        for (int i = 0; i < 50; i++) send_word(32'(i));
        rst = 1'b1;
        send_word(32'd50);
        rst   = 1'b0;
        valid = 1'b0;
        check_zero(0);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done[0]) pulses++;
        end
        check_eq("rst_no_done", 32'(pulses), 32'd0);
        for (int i = 0; i < 5; i++) send_word(32'(i + 7));
        valid = 1'b0;
        check_eq("rst_next_done", {31'd0, done[1]}, 32'd1);
        check_eq("rst_next_pass", {31'd0, pass[1]}, 32'd1);
        check_eq("rst_next_wcnt", {16'd0, wcnt[1]}, 32'd5);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
